// File: rtl/tx_byte_buffer.sv
// Byte FIFO feeding the UART transmit handshake: each byte is presented as a held
// level on TX_D_Valid and retired once the transmitter has gone busy and back to idle.
module tx_byte_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  TIMEOUT_ERR,
  input  logic                  TX_Busy,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_Valid
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [8:0]            TMO_LAST = 9'(ACK_TIMEOUT - 1);
  localparam logic [7:0]            TMO_MAX  = 8'hFF;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [7:0]            tmo_cnt;

  logic wr_ok;
  logic pop;
  logic tmo_hit;
  logic valid_clr;
  logic tmo_fire;
  logic tmo_inc;

  // FULL is the registered flag, so a write in the cycle of a pop from a full FIFO is still rejected
  assign wr_ok   = WR_EN && !FULL;
  assign tmo_hit = {1'b0, tmo_cnt} >= TMO_LAST;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!EMPTY && !TX_Busy) state_nxt = SEND;
      SEND: begin
        if (TX_Busy)      state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!TX_Busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    pop       = 1'b0;
    valid_clr = 1'b0;
    tmo_fire  = 1'b0;
    tmo_inc   = 1'b0;
    unique case (state)
      IDLE: pop = !EMPTY && !TX_Busy;
      SEND: begin
        if (TX_Busy) begin
          valid_clr = 1'b1;
        end else if (tmo_hit) begin
          valid_clr = 1'b1;
          tmo_fire  = 1'b1;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- FIFO storage (never cleared) ----------------
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= WR_DATA;
  end

  always_comb begin
    count_nxt = COUNT;
    unique case ({wr_ok, pop})
      2'b10:   count_nxt = COUNT + CNT_ONE;
      2'b01:   count_nxt = COUNT - CNT_ONE;
      default: count_nxt = COUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      EMPTY  <= 1'b1;
      FULL   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == CNT_FULL);
    end
  end

  // ---------------- Transmit presentation ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_P_DATA  <= '0;
      TX_D_Valid <= 1'b0;
    end else begin
      if (pop)            TX_P_DATA <= mem[rd_ptr];
      if (pop)            TX_D_Valid <= 1'b1;
      else if (valid_clr) TX_D_Valid <= 1'b0;
    end
  end

  // Acknowledge timer saturates rather than wrapping
  always_ff @(posedge CLK) begin
    if (RST || pop)                  tmo_cnt <= '0;
    else if (tmo_inc && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 8'd1;
  end

  // ---------------- Sticky error flags ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVERFLOW    <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (WR_EN && FULL) OVERFLOW    <= 1'b1;
      if (tmo_fire)      TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_byte_buffer.sv
// Scenario bench for tx_byte_buffer: an emulated transmitter collects presented bytes and
// compares them against a queue of everything the bench accepted into the FIFO.
module tb_tx_byte_buffer;
  localparam int DW   = 8;
  localparam int DEP  = 8;
  localparam int AW   = 3;
  localparam int ATMO = 255;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] WR_DATA;
  logic          WR_EN;
  logic          FULL, EMPTY, OVERFLOW, TIMEOUT_ERR;
  logic [AW:0]   COUNT;
  logic          TX_Busy;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_Valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] wr_q[$];
  int rises;
  int unstable;

  tx_byte_buffer #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .ACK_TIMEOUT(ATMO)) dut (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN), .FULL(FULL), .EMPTY(EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .TIMEOUT_ERR(TIMEOUT_ERR), .TX_Busy(TX_Busy),
    .TX_P_DATA(TX_P_DATA), .TX_D_Valid(TX_D_Valid)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    WR_EN = 1'b1; WR_DATA = d; tick(); WR_EN = 1'b0;
  endtask

  task automatic settle();
    WR_EN = 1'b0; TX_Busy = 1'b0;
    repeat (6) tick();
  endtask

  // Transmitter model: on each valid rise take the byte, go busy after 0..3 cycles,
  // stay busy 1..5 cycles. Pending wr_q bytes are written whenever FULL is low.
  task automatic run_tx(input int cycles);
    logic pv; logic [7:0] held; int dly; int hold;
    pv = 1'b0; held = '0; dly = -1; hold = 0;
    got_q.delete(); rises = 0; unstable = 0;
    for (int c = 0; c < cycles; c++) begin
      if (TX_D_Valid && !pv) begin
        got_q.push_back(TX_P_DATA); held = TX_P_DATA; rises++;
        dly = int'($urandom_range(0, 3));
      end else if (TX_D_Valid && TX_P_DATA !== held) unstable++;
      pv = TX_D_Valid;
      if (dly == 0) begin TX_Busy = 1'b1; hold = int'($urandom_range(1, 5)); dly = -1; end
      else if (dly > 0) dly--;
      else if (hold > 0) begin hold--; if (hold == 0) TX_Busy = 1'b0; end
      if (wr_q.size() > 0 && !FULL && $urandom_range(0, 1) == 1) begin
        WR_EN = 1'b1; WR_DATA = wr_q.pop_front(); exp_q.push_back(WR_DATA);
      end else WR_EN = 1'b0;
      tick();
    end
    WR_EN = 1'b0; TX_Busy = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; TX_Busy = 1'b0;
    tick(); tick();
    RST = 1'b0;
    n_cmp++; if (COUNT !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", COUNT); end
    n_cmp++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin n_err++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", EMPTY, FULL); end
    n_cmp++; if (OVERFLOW !== 1'b0 || TIMEOUT_ERR !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got ovf=%b tmo=%b want 0/0", OVERFLOW, TIMEOUT_ERR); end
    n_cmp++; if (TX_D_Valid !== 1'b0 || TX_P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_tx: got v=%b d=%h want 0/00", TX_D_Valid, TX_P_DATA); end
  endtask

  task automatic test_single();
    TX_Busy = 1'b0;
    put(8'hA5);
    n_cmp++; if (TX_D_Valid !== 1'b0 || COUNT !== 4'd1) begin n_err++; $display("FAIL single_edge1: got v=%b cnt=%0d want 0/1", TX_D_Valid, COUNT); end
    tick();
    n_cmp++; if (TX_D_Valid !== 1'b1 || TX_P_DATA !== 8'hA5) begin n_err++; $display("FAIL single_edge2: got v=%b d=%h want 1/a5", TX_D_Valid, TX_P_DATA); end
    n_cmp++; if (COUNT !== 4'd0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL single_pop_count: got cnt=%0d empty=%b want 0/1", COUNT, EMPTY); end
    tick(); tick();
    n_cmp++; if (TX_D_Valid !== 1'b1 || TX_P_DATA !== 8'hA5) begin n_err++; $display("FAIL single_hold: got v=%b d=%h want 1/a5", TX_D_Valid, TX_P_DATA); end
    TX_Busy = 1'b1; tick();
    n_cmp++; if (TX_D_Valid !== 1'b0) begin n_err++; $display("FAIL single_busy_drop: got v=%b want 0", TX_D_Valid); end
    tick(); TX_Busy = 1'b0; tick(); tick();
    n_cmp++; if (TX_D_Valid !== 1'b0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL single_done: got v=%b empty=%b want 0/1", TX_D_Valid, EMPTY); end
  endtask

  task automatic test_burst();
    TX_Busy = 1'b1;
    exp_q.delete(); wr_q.delete();
    for (int i = 1; i <= 8; i++) begin put(8'(i)); exp_q.push_back(8'(i)); end
    n_cmp++; if (FULL !== 1'b1 || COUNT !== 4'd8) begin n_err++; $display("FAIL burst_full: got full=%b cnt=%0d want 1/8", FULL, COUNT); end
    n_cmp++; if (OVERFLOW !== 1'b0) begin n_err++; $display("FAIL burst_no_ovf: got %b want 0", OVERFLOW); end
    put(8'hFF);
    n_cmp++; if (OVERFLOW !== 1'b1 || COUNT !== 4'd8) begin n_err++; $display("FAIL burst_overflow: got ovf=%b cnt=%0d want 1/8", OVERFLOW, COUNT); end
    TX_Busy = 1'b0;
    run_tx(200);
    n_cmp++; if (rises !== 8) begin n_err++; $display("FAIL burst_rises: got %0d want 8", rises); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL burst_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL burst_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (unstable !== 0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL burst_end: got unstable=%0d empty=%b want 0/1", unstable, EMPTY); end
    settle();
  endtask

  task automatic test_simul();
    logic [7:0] b;
    exp_q.delete(); wr_q.delete();
    TX_Busy = 1'b1;
    for (int i = 0; i < 3; i++) begin b = 8'($urandom); put(b); exp_q.push_back(b); end
    n_cmp++; if (COUNT !== 4'd3) begin n_err++; $display("FAIL simul_pre: got %0d want 3", COUNT); end
    TX_Busy = 1'b0;
    b = 8'($urandom); put(b); exp_q.push_back(b);
    n_cmp++; if (COUNT !== 4'd3) begin n_err++; $display("FAIL simul_count: got %0d want 3", COUNT); end
    n_cmp++; if (TX_D_Valid !== 1'b1 || TX_P_DATA !== exp_q[0]) begin n_err++; $display("FAIL simul_pop: got v=%b d=%h want 1/%h", TX_D_Valid, TX_P_DATA, exp_q[0]); end
    for (int i = 0; i < 16; i++) wr_q.push_back(8'($urandom));
    run_tx(500);
    n_cmp++; if (got_q.size() !== 20 || exp_q.size() !== 20) begin n_err++; $display("FAIL wrap_len: got %0d want 20", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL wrap_stable: got %0d want 0", unstable); end
    settle();
  endtask

  task automatic test_timeout();
    int hi;
    TX_Busy = 1'b0;
    put(8'h3C); tick();
    n_cmp++; if (TX_D_Valid !== 1'b1 || TX_P_DATA !== 8'h3C) begin n_err++; $display("FAIL tmo_start: got v=%b d=%h want 1/3c", TX_D_Valid, TX_P_DATA); end
    n_cmp++; if (TIMEOUT_ERR !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", TIMEOUT_ERR); end
    hi = 0;
    for (int c = 0; c < 400 && TX_D_Valid === 1'b1; c++) begin hi++; tick(); end
    n_cmp++; if (hi !== ATMO) begin n_err++; $display("FAIL tmo_width: got %0d want %0d", hi, ATMO); end
    n_cmp++; if (TIMEOUT_ERR !== 1'b1 || TX_D_Valid !== 1'b0) begin n_err++; $display("FAIL tmo_flag: got err=%b v=%b want 1/0", TIMEOUT_ERR, TX_D_Valid); end
    exp_q.delete(); wr_q.delete(); wr_q.push_back(8'h3D);
    run_tx(60);
    n_cmp++; if (rises !== 1 || got_q.size() !== 1) begin n_err++; $display("FAIL tmo_next_count: got %0d want 1", rises); end
    else begin n_cmp++; if (got_q[0] !== 8'h3D) begin n_err++; $display("FAIL tmo_next_byte: got %h want 3d", got_q[0]); end end
    n_cmp++; if (TIMEOUT_ERR !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", TIMEOUT_ERR); end
    settle();
  endtask

  task automatic test_busy_start();
    int seen;
    TX_Busy = 1'b1;
    put(8'h5A);
    seen = 0;
    for (int c = 0; c < 6; c++) begin if (TX_D_Valid !== 1'b0) seen++; tick(); end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL busy_hold_off: got %0d valid cycles want 0", seen); end
    TX_Busy = 1'b0; tick();
    n_cmp++; if (TX_D_Valid !== 1'b1 || TX_P_DATA !== 8'h5A) begin n_err++; $display("FAIL busy_release: got v=%b d=%h want 1/5a", TX_D_Valid, TX_P_DATA); end
    TX_Busy = 1'b1; tick(); tick();
    settle();
  endtask

  task automatic test_reset_mid();
    TX_Busy = 1'b1;
    put(8'h11); put(8'h22); put(8'h33);
    TX_Busy = 1'b0; tick(); tick();
    n_cmp++; if (TX_D_Valid !== 1'b1 || OVERFLOW !== 1'b1 || TIMEOUT_ERR !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got v=%b ovf=%b tmo=%b want 1/1/1", TX_D_Valid, OVERFLOW, TIMEOUT_ERR); end
    RST = 1'b1; tick(); RST = 1'b0;
    n_cmp++; if (TX_D_Valid !== 1'b0 || COUNT !== 4'd0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL rmid_state: got v=%b cnt=%0d empty=%b want 0/0/1", TX_D_Valid, COUNT, EMPTY); end
    n_cmp++; if (TIMEOUT_ERR !== 1'b0 || OVERFLOW !== 1'b0) begin n_err++; $display("FAIL rmid_sticky: got tmo=%b ovf=%b want 0/0", TIMEOUT_ERR, OVERFLOW); end
    exp_q.delete(); wr_q.delete();
    for (int i = 0; i < 12; i++) wr_q.push_back(8'($urandom));
    run_tx(400);
    n_cmp++; if (got_q.size() !== 12 || exp_q.size() !== 12) begin n_err++; $display("FAIL rmid_len: got %0d want 12", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmid_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_byte_buffer.md
Name: tx_byte_buffer

Overview:
- Byte FIFO plus transmit-handshake sequencer between the system controller's transmit byte output and the UART transmitter path.
- Sits on the REF_CLK side, upstream of the controller-to-TX data synchroniser.
- Lets the controller burst multi-byte responses (for example, a 16-bit ALU result as two bytes) without polling TX_Busy.
- Presents one byte at a time as a held level and releases it only after the transmitter reports busy and then idle.

Parameters:
- DATA_WIDTH, 8, byte width.
- DEPTH, 8, FIFO entries; must be a power of 2.
- ADDR_WIDTH, 3, log2(DEPTH).
- ACK_TIMEOUT, 255, maximum REF_CLK cycles to wait for TX_Busy to rise after TX_D_Valid is raised.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  synchronous, active-high reset.
- WR_DATA  in  DATA_WIDTH  byte from the controller.
- WR_EN  in  1  single-cycle write strobe.
- FULL  out  1  FIFO holds DEPTH entries.
- EMPTY  out  1  FIFO holds 0 entries.
- COUNT  out  ADDR_WIDTH+1  current occupancy.
- OVERFLOW  out  1  sticky; a write was attempted while FULL.
- TIMEOUT_ERR  out  1  sticky; the transmitter did not acknowledge within ACK_TIMEOUT.
- TX_Busy  in  1  transmitter busy, already synchronised into CLK.
- TX_P_DATA  out  DATA_WIDTH  byte presented to the synchroniser.
- TX_D_Valid  out  1  level-held valid to the synchroniser.

Behaviour:
- Reset (RST high at a rising edge):
  - Pointers and COUNT = 0; EMPTY = 1; FULL = 0.
  - OVERFLOW = 0; TIMEOUT_ERR = 0.
  - TX_P_DATA = 0; TX_D_Valid = 0; FSM returns to IDLE.
  - FIFO contents are not cleared.
  - Reset mid-transfer drops TX_D_Valid at that edge and discards any in-flight byte.
- All outputs are registered.
  - FULL, EMPTY and COUNT reflect state after the last edge.
- Write:
  - WR_EN=1 and FULL=0 → mem[wr_ptr] <= WR_DATA, wr_ptr++ (modulo DEPTH), COUNT+1 at the same edge.
  - WR_EN=1 and FULL=1 → data is dropped, pointers are unchanged, OVERFLOW <= 1.
  - FULL is sampled pre-edge, so a write is rejected even if a pop occurs in the same cycle.
- Pop: happens only on the IDLE→SEND transition.
  - TX_P_DATA <= mem[rd_ptr], rd_ptr++ (wrap), COUNT-1.
  - Pop and accepted write in the same cycle → COUNT unchanged; both pointers advance.
- FSM states: IDLE, SEND, WAIT_DONE.
  - IDLE: if EMPTY=0 and TX_Busy=0 → pop, TX_D_Valid <= 1, clear timeout counter, go to SEND. Otherwise stay; TX_D_Valid = 0.
  - SEND: TX_D_Valid and TX_P_DATA are held stable.
    - TX_Busy=1 → TX_D_Valid <= 0, go to WAIT_DONE.
    - Else timeout counter +1; when it reaches ACK_TIMEOUT → TX_D_Valid <= 0, TIMEOUT_ERR <= 1, go to IDLE. The byte is discarded.
  - WAIT_DONE: TX_Busy=0 → go to IDLE. Otherwise stay.
- Latency: a write into an empty FIFO with the transmitter idle gives TX_D_Valid=1 two edges after the WR_EN edge.
  - One edge to write, then the IDLE pop edge.
- Back-to-back bytes: the next TX_D_Valid rises at the earliest one cycle after TX_Busy is seen low.
  - Every byte produces a distinct valid rising edge for the downstream pulse generator.
- TX_P_DATA changes only on a pop edge; it holds its last value otherwise.
- Timeout counter is 8 bits; it saturates and never wraps.
- Sticky flags clear only on RST.

Test Plan:
- Reset mid-transfer: assert RST while in SEND → next edge TX_D_Valid=0, COUNT=0, EMPTY=1, TIMEOUT_ERR=0.
- Single byte: write 0xA5, TX_Busy low → TX_D_Valid=1 with TX_P_DATA=0xA5 two edges later.
  - Raise TX_Busy 3 cycles later → TX_D_Valid=0 next edge.
  - Drop TX_Busy → IDLE; EMPTY=1.
- Burst: write 0x01..0x08 back-to-back → FULL=1 and COUNT=8 after the 8th write.
  - A 9th write of 0xFF → OVERFLOW=1; 0xFF is never transmitted.
  - Emulated transmitter yields the output sequence 0x01..0x08 in order, with exactly 8 TX_D_Valid rising edges.
- Simultaneous pop/write: with COUNT=3 in IDLE, write at the same edge as the pop → COUNT stays 3.
  - Wrap-around over 20 bytes preserves order.
- Timeout: write 0x3C, hold TX_Busy=0 → TX_D_Valid high for exactly ACK_TIMEOUT cycles, then low and TIMEOUT_ERR=1.
  - A subsequent byte 0x3D is still sent normally.
- Busy at start: TX_Busy=1 (previous frame) when the first byte is written → TX_D_Valid stays 0 until TX_Busy falls, then rises one edge later.
